// File: rtl/memstream_loader.sv
// memstream_loader: turns a load command plus an AXI-Stream of words into memstream config-port writes.
// Define MEMSTREAM_LOADER_VERIFY_EN to compile in the read-back checksum pass over the loaded region.
module memstream_loader #(
    parameter int MEM_DEPTH    = 9216,
    parameter int MEM_WIDTH    = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_len,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [MEM_WIDTH-1:0] s_axis_tdata,
    output logic [31:0]          config_address,
    output logic                 config_ce,
    output logic                 config_we,
    output logic [MEM_WIDTH-1:0] config_d0,
    input  logic [MEM_WIDTH-1:0] config_q0,
    output logic                 done,
    output logic                 err,
    output logic                 busy
);
    localparam logic [31:0] DEPTH     = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_ADDR = 32'(MEM_DEPTH - 1);

`ifdef MEMSTREAM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WRITE, VERIFY_RD, VERIFY_WAIT, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
`endif

    state_t      state;
    state_t      next_state;
    logic [31:0] ptr;
    logic [31:0] remaining;
    logic [31:0] ptr_next;
    logic        cmd_fire;
    logic        beat_fire;
    logic        last_beat;
    logic        cmd_bad_addr;
    logic        cmd_empty;

    assign cmd_fire     = cmd_valid & cmd_ready;
    assign beat_fire    = s_axis_tvalid & s_axis_tready;
    assign last_beat    = (remaining == 32'd1);
    assign ptr_next     = (ptr == LAST_ADDR) ? 32'd0 : ptr + 32'd1;
    assign cmd_bad_addr = (cmd_addr >= DEPTH);
    assign cmd_empty    = (cmd_len == 32'd0);

`ifdef MEMSTREAM_LOADER_VERIFY_EN
    logic [31:0]             base_addr;
    logic [31:0]             base_len;
    logic [MEM_WIDTH-1:0]    wr_sum;
    logic [MEM_WIDTH-1:0]    rd_sum;
    logic [READ_LATENCY-1:0] rd_pending;
    logic                    rd_strobe;
    logic                    rd_drained;

    // A read is in flight from its registered strobe until its data is folded into rd_sum.
    assign rd_strobe  = config_ce & ~config_we;
    assign rd_drained = ~rd_strobe & (rd_pending == '0);
`else
    logic unused_q0;
    assign unused_q0 = ^config_q0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        cmd_ready     = 1'b0;
        s_axis_tready = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                // Gated by reset so the command port stays closed while reset is held.
                cmd_ready = aresetn;
                busy      = 1'b0;
                if (cmd_fire) begin
                    next_state = (cmd_bad_addr || cmd_empty) ? FIN : WRITE;
                end
            end
            WRITE: begin
                s_axis_tready = 1'b1;
                if (beat_fire && last_beat) begin
`ifdef MEMSTREAM_LOADER_VERIFY_EN
                    next_state = VERIFY_RD;
`else
                    next_state = FIN;
`endif
                end
            end
`ifdef MEMSTREAM_LOADER_VERIFY_EN
            VERIFY_RD: begin
                if (last_beat) begin
                    next_state = VERIFY_WAIT;
                end
            end
            VERIFY_WAIT: begin
                if (rd_drained) begin
                    next_state = FIN;
                end
            end
`endif
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr            <= '0;
            remaining      <= '0;
            err            <= 1'b0;
            config_ce      <= 1'b0;
            config_we      <= 1'b0;
            config_address <= '0;
            config_d0      <= '0;
        end else begin
            config_ce <= 1'b0;
            config_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        ptr       <= cmd_addr;
                        remaining <= cmd_len;
                        err       <= cmd_bad_addr;
                    end
                end
                WRITE: begin
                    if (beat_fire) begin
                        config_ce      <= 1'b1;
                        config_we      <= 1'b1;
                        config_address <= ptr;
                        config_d0      <= s_axis_tdata;
                        ptr            <= ptr_next;
                        remaining      <= remaining - 32'd1;
`ifdef MEMSTREAM_LOADER_VERIFY_EN
                        // Rewind to the start of the region for the read-back pass.
                        if (last_beat) begin
                            ptr       <= base_addr;
                            remaining <= base_len;
                        end
`endif
                    end
                end
`ifdef MEMSTREAM_LOADER_VERIFY_EN
                VERIFY_RD: begin
                    config_ce      <= 1'b1;
                    config_address <= ptr;
                    ptr            <= ptr_next;
                    remaining      <= remaining - 32'd1;
                end
                VERIFY_WAIT: begin
                    if (rd_drained) begin
                        err <= (rd_sum != wr_sum);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef MEMSTREAM_LOADER_VERIFY_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            base_addr  <= '0;
            base_len   <= '0;
            wr_sum     <= '0;
            rd_sum     <= '0;
            rd_pending <= '0;
        end else begin
            rd_pending[0] <= rd_strobe;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pending[i] <= rd_pending[i-1];
            end
            if (rd_pending[READ_LATENCY-1]) begin
                rd_sum <= rd_sum ^ config_q0;
            end
            if (cmd_fire) begin
                base_addr <= cmd_addr;
                base_len  <= cmd_len;
                wr_sum    <= '0;
                rd_sum    <= '0;
            end else if (beat_fire) begin
                wr_sum <= wr_sum ^ s_axis_tdata;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memstream_loader.sv
// Randomized bench for memstream_loader: a memory model on the config port plus a region-level
// reference of expected writes, beat consumption, done timing and err.
module tb_memstream_loader;
    localparam int          DEPTH = 9216;
    localparam int          RL    = 2;
    localparam logic [31:0] MASK  = 32'hDEAD_BEEF;
`ifdef MEMSTREAM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_len;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [31:0] config_address;
    logic        config_ce;
    logic        config_we;
    logic [31:0] config_d0;
    logic [31:0] config_q0;
    logic        done;
    logic        err;
    logic        busy;

    memstream_loader #(
        .MEM_DEPTH(DEPTH),
        .MEM_WIDTH(32),
        .READ_LATENCY(RL)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .config_address(config_address),
        .config_ce(config_ce),
        .config_we(config_we),
        .config_d0(config_d0),
        .config_q0(config_q0),
        .done(done),
        .err(err),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rd_count = 0;
    int done_count = 0;
    int beats_taken = 0;
    bit cmd_finished = 1'b0;
    bit corrupt_en = 1'b0;

    logic [31:0] stim_data[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];

    // Memory behind the config port; reads return data RL cycles after the strobe cycle.
    logic [31:0] mem[DEPTH];
    logic [31:0] rd_pipe[RL];

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (config_ce && config_we && config_address < 32'(DEPTH))
            mem[config_address[13:0]] <= config_d0;
        if (config_ce && !config_we && config_address < 32'(DEPTH))
            rd_pipe[0] <= mem[config_address[13:0]] ^
                          ((corrupt_en && config_address == 32'd3) ? MASK : 32'd0);
        else
            rd_pipe[0] <= $urandom;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign config_q0 = rd_pipe[RL-1];

    always @(negedge aclk) begin
        if (config_ce && config_we) begin
            obs_addr.push_back(config_address);
            obs_data.push_back(config_d0);
            obs_cyc.push_back(cyc);
        end
        if (config_ce && !config_we) rd_count++;
        if (done) done_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents stim_data[0..n-1] in order, then keeps offering stray beats that must never be taken.
    task automatic drive_stream(input int n, input bit gaps, input int budget);
        int i = 0;
        int guard = 0;
        while (!cmd_finished && guard < budget) begin
            @(negedge aclk);
            guard++;
            if (i < n) begin
                s_axis_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                s_axis_tdata  = stim_data[i];
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = $urandom;
            end
            #1;
            if (s_axis_tvalid && s_axis_tready) begin
                if (i < n) i++;
                beats_taken++;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] len,
                                 input bit gaps, input bit timed);
        bit   bad;
        int   n_eff;
        bit   covers3;
        logic exp_err;
        int   accept_cyc, done_cyc, g, rd_base, exp_lat;
        logic seen, ready_seen, err_obs, done_after, busy_after, ready_after;
        bad     = (addr >= 32'(DEPTH));
        n_eff   = bad ? 0 : int'(len);
        covers3 = 1'b0;
        for (int i = 0; i < n_eff; i++)
            if (((longint'(addr) + i) % DEPTH) == 3) covers3 = 1'b1;
        exp_err = bad || (VERIFY && corrupt_en && covers3);
        exp_lat = (n_eff == 0) ? 0 : (VERIFY ? 2 * n_eff + RL + 2 : n_eff);
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        rd_base      = rd_count;
        beats_taken  = 0;
        cmd_finished = 1'b0;
        seen = 0; ready_seen = 0; err_obs = 0; done_after = 1; busy_after = 1; ready_after = 0;
        accept_cyc = 0; done_cyc = 0;
        fork
            begin
                @(negedge aclk);
                cmd_addr  = addr;
                cmd_len   = len;
                cmd_valid = 1'b1;
                #1;
                g = 0;
                while (!cmd_ready && g < 50) begin
                    @(negedge aclk);
                    #1;
                    g++;
                end
                ready_seen = cmd_ready;
                accept_cyc = cyc + 1;
                @(negedge aclk);
                cmd_valid = 1'b0;
                g = 0;
                while (!done && g < 100 + 4 * n_eff) begin
                    @(negedge aclk);
                    g++;
                end
                seen     = done;
                err_obs  = err;
                done_cyc = cyc;
                @(negedge aclk);
                done_after  = done;
                busy_after  = busy;
                ready_after = cmd_ready;
                cmd_finished = 1'b1;
            end
            drive_stream(n_eff, gaps, 400 + 8 * n_eff);
        join
        checkOutput("cmd_accepted", 32'(ready_seen), 32'd1);
        checkOutput("done_seen", 32'(seen), 32'd1);
        checkOutput("done_err", 32'(err_obs), 32'(exp_err));
        checkOutput("done_one_cycle", 32'(done_after), 32'd0);
        checkOutput("idle_busy", 32'(busy_after), 32'd0);
        checkOutput("idle_cmd_ready", 32'(ready_after), 32'd1);
        checkOutput("beats_taken", 32'(beats_taken), 32'(n_eff));
        checkOutput("write_count", 32'(obs_addr.size()), 32'(n_eff));
        checkOutput("read_count", 32'(rd_count - rd_base), VERIFY ? 32'(n_eff) : 32'd0);
        if (timed && seen)
            checkOutput("done_latency", 32'(done_cyc - accept_cyc), 32'(exp_lat));
        for (int i = 0; i < n_eff && i < obs_addr.size(); i++) begin
            checkOutput("write_addr", obs_addr[i], 32'((longint'(addr) + i) % DEPTH));
            checkOutput("write_data", obs_data[i], stim_data[i]);
            if (timed) checkOutput("write_spacing", 32'(obs_cyc[i] - obs_cyc[0]), 32'(i));
        end
    endtask

    task automatic fill_random(input int n);
        stim_data.delete();
        for (int i = 0; i < n; i++) stim_data.push_back($urandom);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_base;
        logic [31:0] addr;
        int len;
        aresetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        repeat (3) @(negedge aclk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_ce", 32'(config_ce), 32'd0);
        checkOutput("rst_we", 32'(config_we), 32'd0);
        checkOutput("rst_addr", config_address, 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        aresetn = 1'b1;
        #1;
        checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        stim_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        applyStimulus(32'd0, 32'd4, 1'b0, 1'b1);
        fill_random(4);
        applyStimulus(32'd9214, 32'd4, 1'b0, 1'b1);
        fill_random(3);
        applyStimulus(32'd100, 32'd3, 1'b1, 1'b0);
        fill_random(5);
        applyStimulus(32'd9216, 32'd5, 1'b0, 1'b1);
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b1);

        fill_random(8);
        corrupt_en = 1'b1;
        applyStimulus(32'd0, 32'd8, 1'b0, 1'b1);
        corrupt_en = 1'b0;
        fill_random(8);
        applyStimulus(32'd0, 32'd8, 1'b0, 1'b1);

        // Reset lands while the second of ten beats is being written.
        fill_random(10);
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        @(negedge aclk);
        cmd_addr = 32'd0;
        cmd_len = 32'd10;
        cmd_valid = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = stim_data[0];
        #1 checkOutput("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(negedge aclk);
        s_axis_tdata = stim_data[1];
        @(negedge aclk);
        #2;
        checkOutput("mid_ce_before", 32'(config_ce), 32'd1);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        done_base = done_count;
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        checkOutput("mid_ce_dropped", 32'(config_ce), 32'd0);
        checkOutput("mid_done_low", 32'(done), 32'd0);
        checkOutput("mid_cmd_ready_low", 32'(cmd_ready), 32'd0);
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checkOutput("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("mid_rel_busy", 32'(busy), 32'd0);
        checkOutput("mid_no_done", 32'(done_count - done_base), 32'd0);
        checkOutput("mid_write_count", 32'(obs_addr.size()), 32'd2);
        fill_random(1);
        applyStimulus(32'd0, 32'd1, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: addr = 32'($urandom_range(0, DEPTH - 1));
                1: addr = 32'(DEPTH - 1 - $urandom_range(0, 5));
                2: addr = 32'(DEPTH + $urandom_range(0, 100));
                default: addr = 32'($urandom_range(0, 10));
            endcase
            len = $urandom_range(0, 12);
            fill_random(len);
            corrupt_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                applyStimulus(addr, 32'(len), 1'b1, 1'b0);
            else
                applyStimulus(addr, 32'(len), 1'b0, 1'b1);
        end
        corrupt_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/memstream_loader.md
# memstream_loader

Stream-to-memory loader sitting on the configuration side of `memstream`. It accepts a load command (base address, word count) and then consumes an AXI-Stream of weight words. Each accepted word becomes one write on the memstream configuration port (`config_address/ce/we/d0`), so weight memories can be refreshed at run time from a DMA stream instead of through AXI-Lite. An optional read-back pass checks the loaded region.

## Interface
Parameters:
- MEM_DEPTH, 9216, memory depth in words; the address space is 0..MEM_DEPTH-1.
- MEM_WIDTH, 32, word width; applies to `s_axis_tdata`, `config_d0` and `config_q0`.
- READ_LATENCY, 2, cycles from a config read strobe (`ce=1`, `we=0`) to valid `config_q0`; range 1..4.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  load command valid.
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`.
- cmd_addr  in  32  base word address.
- cmd_len  in  32  number of words to load.
- s_axis_tvalid  in  1  input data valid.
- s_axis_tready  out  1  input data ready.
- s_axis_tdata  in  MEM_WIDTH  weight word.
- config_address  out  32  memory word address.
- config_ce  out  1  memory access strobe.
- config_we  out  1  write enable (1 = write, 0 = read).
- config_d0  out  MEM_WIDTH  write data.
- config_q0  in  MEM_WIDTH  read data.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  status, valid while `done` = 1; held until the next accepted command.
- busy  out  1  high from command accept until `done`.

## Operation
- States: IDLE, WRITE, VERIFY_RD, VERIFY_WAIT, FIN.
- IDLE:
  - `cmd_ready` = 1.
  - On accept, latch `cmd_addr`, `cmd_len` and clear the checksum and `err`.
  - `cmd_addr >= MEM_DEPTH`: go to FIN with `err` = 1. No memory access is made.
  - `cmd_len == 0`: go to FIN with `err` = 0. No memory access is made.
  - Otherwise go to WRITE.
- WRITE:
  - `s_axis_tready` = 1.
  - Each accepted beat registers `config_ce` = 1, `config_we` = 1, `config_address` = current pointer and `config_d0` = tdata for exactly one cycle.
  - On the same beat, XOR tdata into the checksum, increment the pointer and decrement the remaining count.
  - The pointer wraps from MEM_DEPTH-1 to 0.
  - After the last beat, go to VERIFY_RD if verify is compiled in, otherwise to FIN.
- VERIFY_RD:
  - Reload the pointer to `cmd_addr` and the count to `cmd_len`.
  - Issue one read per cycle (`ce` = 1, `we` = 0) with the same wrap rule.
  - Track a READ_LATENCY-deep valid shift register; XOR each returned `config_q0` into a readback checksum.
  - After the last read is issued, go to VERIFY_WAIT.
- VERIFY_WAIT: wait until the shift register is empty, then set `err` = (readback checksum != write checksum) and go to FIN.
- FIN: `done` = 1 for one cycle, then go to IDLE.
- `s_axis_tready` = 0 in every state except WRITE. Beats arriving outside a command are stalled, never dropped.
- `cmd_ready` = 0 in every state except IDLE.
- Pointer and count are 32-bit; the pointer compare for wrap is `== MEM_DEPTH-1`.

## Timing
- Reset values: `cmd_ready` = 0 during reset and 1 in the first cycle after release; all other outputs 0; `config_address` = 0.
- Write latency: a beat accepted at edge N shows `config_ce`/`config_we` high at edge N+1 and low at N+2 unless another beat is accepted.
- Throughput is one word per cycle; upstream tvalid gaps produce `ce` = 0 cycles.
- Minimum command-to-`done` time with verify: `cmd_len` write cycles + `cmd_len` read cycles + READ_LATENCY + 2.
- Reset mid-operation: return to IDLE immediately, abandon the remaining count, drop `ce` asynchronously, do not pulse `done`.
- `cmd_valid` while busy is held off; it is not queued.

## Configuration
- Macro `MEMSTREAM_LOADER_VERIFY_EN`.
- Defined: read-back checksum pass as above; `err` reports both checksum mismatch and a bad address.
- Undefined: VERIFY_RD and VERIFY_WAIT are absent, `config_q0` is unused, `config_we` is 1 whenever `config_ce` is 1, and `err` reports only a bad address.

## Test plan
- Basic load: cmd (addr=0, len=4), data 0x11,0x22,0x33,0x44 back-to-back -> four writes at addresses 0..3 on consecutive cycles; `done` with `err` = 0.
- Wrap: cmd (addr=9214, len=4) -> writes at 9214, 9215, 0, 1.
- Upstream gaps: cmd (addr=100, len=3) with tvalid toggling randomly -> exactly three writes at addresses 100..102, data in order; tready low outside WRITE.
- Degenerate commands:
  - cmd (addr=9216, len=5) -> no `ce`; `done` with `err` = 1.
  - cmd (addr=5, len=0) -> no `ce`; `done` with `err` = 0.
- Verify mismatch (VERIFY_EN, READ_LATENCY=2): load 8 words into a model memory that corrupts address 3 -> `done` with `err` = 1. Repeat with the model clean -> `err` = 0.
- Reset mid-WRITE: assert `aresetn` low after 2 of 10 beats -> `ce` low immediately, no `done`. After release, `cmd_ready` = 1 and a new cmd (addr=0, len=1) completes normally.
